// File: rtl/seq_divider8_pkg.sv
// Shared definitions for the sequential signed divider.
// Contents: FSM state encodings, default operand and counter widths, and the
// quotient value returned on divide-by-zero.
package seq_divider8_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // Divide-by-zero reports a quotient of -1 (all ones).
    localparam logic [WIDTH_DEF-1:0] DBZ_QUOT = {WIDTH_DEF{1'b1}};

endpackage

// File: rtl/adder8bit.sv
// Ripple-free behavioural adder with carry-in and carry-out.
// Ports:
//   a, b  : WIDTH-bit addends
//   cin   : carry in
//   sum   : WIDTH-bit sum
//   cout  : carry out
module adder8bit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_divider8.sv
// Iterative signed divider, one quotient bit per clock (restoring algorithm).
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   start               : request a division (honoured only when idle)
//   dividend, divisor   : signed operands, captured when start is accepted
//   quotient, remainder : signed results, valid from the done cycle onward
//   busy                : operation in progress
//   done                : one-cycle completion pulse
//   dbz, ovf            : divide-by-zero / overflow flags of the last result
module seq_divider8
    import seq_divider8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Two's-complement negation within WIDTH bits.
    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
        neg2c = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude as an unsigned value; the most negative input maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            mag = neg2c(v);
        end else begin
            mag = v;
        end
    endfunction

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] dvs_mag_r;
    // The partial remainder is always below the divisor magnitude (<= 2^(WIDTH-1)),
    // so WIDTH bits hold it; the shifted value p_shift_s carries the WIDTH+1 bits.
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] q_r;
    logic             sign_q_r;
    logic             sign_r_r;
    logic             dbz_int_r;
    logic             ovf_int_r;

    logic [WIDTH:0]   p_shift_s;
    logic [WIDTH-1:0] q_shift_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic [WIDTH:0]   t_s;

    assign p_shift_s = {p_r, q_r[WIDTH-1]};
    assign q_shift_s = {q_r[WIDTH-2:0], 1'b0};

    // T = P_shifted - {0,|divisor|} as P + ~|divisor| + 1.
    adder8bit #(.WIDTH(WIDTH)) u_sub (
        .a    (p_shift_s[WIDTH-1:0]),
        .b    (~dvs_mag_r),
        .cin  (1'b1),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Sign bit of the WIDTH+1-bit difference: no carry out means a borrow.
    assign t_s = {p_shift_s[WIDTH] ^ ~cout_s, sum_s};

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            dvd_r     <= ZERO_W;
            dvs_r     <= ZERO_W;
            dvs_mag_r <= ZERO_W;
            p_r       <= ZERO_W;
            q_r       <= ZERO_W;
            sign_q_r  <= 1'b0;
            sign_r_r  <= 1'b0;
            dbz_int_r <= 1'b0;
            ovf_int_r <= 1'b0;
            quotient  <= ZERO_W;
            remainder <= ZERO_W;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        dvd_r   <= dividend;
                        dvs_r   <= divisor;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    q_r       <= mag(dvd_r);
                    dvs_mag_r <= mag(dvs_r);
                    sign_q_r  <= dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1];
                    sign_r_r  <= dvd_r[WIDTH-1];
                    p_r       <= ZERO_W;
                    cnt_r     <= {CNT_W{1'b0}};
                    dbz_int_r <= (dvs_r == ZERO_W);
                    ovf_int_r <= (dvd_r == MOST_NEG) && (dvs_r == ALL_ONES);
                    busy      <= 1'b1;
                    state_r   <= ST_ITER;
                end
                ST_ITER: begin
                    if (!t_s[WIDTH]) begin
                        p_r <= t_s[WIDTH-1:0];
                        q_r <= {q_shift_s[WIDTH-1:1], 1'b1};
                    end else begin
                        p_r <= p_shift_s[WIDTH-1:0];
                        q_r <= q_shift_s;
                    end
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (dbz_int_r) begin
                        quotient  <= DBZ_QUOT;
                        remainder <= dvd_r;
                    end else if (ovf_int_r) begin
                        quotient  <= MOST_NEG;
                        remainder <= ZERO_W;
                    end else begin
                        quotient  <= sign_q_r ? neg2c(q_r) : q_r;
                        remainder <= sign_r_r ? neg2c(p_r) : p_r;
                    end
                    dbz     <= dbz_int_r;
                    ovf     <= ovf_int_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: a transaction-level reference model
// (integer division plus a fixed 10-cycle latency) checked every cycle, and
// literal expectations for the directed cases.
module tb_seq_divider8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;
    logic       ovf;

    int tests_run = 0;
    int tests_failed = 0;

    seq_divider8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic d, output logic o);
        int ia, ib, iq, ir;
        ia = $signed(a);
        ib = $signed(b);
        d = 1'b0;
        o = 1'b0;
        if (ib == 0) begin
            q = 8'hFF; r = a; d = 1'b1;
        end else if (ia == -128 && ib == -1) begin
            q = 8'h80; r = 8'h00; o = 1'b1;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            q = iq[7:0];
            r = ir[7:0];
        end
    endfunction

    // Transaction model: one op in flight, result appears 10 edges after acceptance.
    bit         m_valid = 0;
    bit         m_pend = 0;
    int         m_k = 0;
    int         m_acc = 0;
    int         m_done_k = -1;
    logic [7:0] nq, nr, eq, er;
    logic       nd, no, ed, eo;

    // Model update on each rising edge, from the inputs the DUT samples.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1;
            m_pend = 0;
            m_k = 0;
            m_done_k = -1;
            eq = 8'h00; er = 8'h00; ed = 1'b0; eo = 1'b0;
        end else begin
            m_k++;
            if (m_pend && m_k == m_acc + 10) begin
                eq = nq; er = nr; ed = nd; eo = no;
                m_pend = 0;
                m_done_k = m_k;
            end else if (!m_pend && start) begin
                m_pend = 1;
                m_acc = m_k;
                ref_div(dividend, divisor, nq, nr, nd, no);
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_busy", {7'd0, busy}, {7'd0, (m_pend && m_k >= m_acc + 1)});
            chk("model_done", {7'd0, done}, {7'd0, (m_k == m_done_k)});
            chk("model_quot", quotient, eq);
            chk("model_rem", remainder, er);
            chk("model_dbz", {7'd0, dbz}, {7'd0, ed});
            chk("model_ovf", {7'd0, ovf}, {7'd0, eo});
        end
    end

    // Issue one division; optionally pulse start mid-operation and check literals.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit pulse,
                         input bit lit, input logic [7:0] xq, input logic [7:0] xr,
                         input logic xd, input logic xo);
        int n;
        bit got;
        @(posedge clk); #1;
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; got = 0;
        while (n < 20 && !got) begin
            @(posedge clk); n++; #1;
            if (pulse && (n == 3 || n == 7)) begin
                start = 1'b1;
                dividend = 8'($urandom);
                divisor = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) got = 1;
        end
        chk("latency", 8'(n), 8'd10);
        if (lit) begin
            chk("lit_quot", quotient, xq);
            chk("lit_rem", remainder, xr);
            chk("lit_dbz", {7'd0, dbz}, {7'd0, xd});
            chk("lit_ovf", {7'd0, ovf}, {7'd0, xo});
        end
    endtask

    // Wait for done with a bound; returns number of edges waited.
    task automatic wait_done(output int n);
        bit got;
        n = 0; got = 0;
        while (n < 20 && !got) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (done) got = 1;
        end
    endtask

    initial begin
        logic [7:0] pq, pr;
        logic       pd, po;
        logic [7:0] ra, rb;
        int         n, dcnt;

        rst_n = 1'b0; start = 1'b0; dividend = 8'h00; divisor = 8'h00;

        // Pin the reference model with hand-computed values.
        ref_div(8'd100, 8'd7, pq, pr, pd, po);
        chk("pin_100_7_q", pq, 8'h0E);
        chk("pin_100_7_r", pr, 8'h02);
        ref_div(8'h9C, 8'd7, pq, pr, pd, po);
        chk("pin_m100_7_q", pq, 8'hF2);
        chk("pin_m100_7_r", pr, 8'hFE);
        ref_div(8'h80, 8'hFF, pq, pr, pd, po);
        chk("pin_ovf_q", pq, 8'h80);
        chk("pin_ovf_o", {7'd0, po}, 8'd1);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_quot", quotient, 8'h00);
        chk("rst_rem", remainder, 8'h00);
        chk("rst_dbz", {7'd0, dbz}, 8'd0);
        chk("rst_ovf", {7'd0, ovf}, 8'd0);

        // Directed cases, including ignored start pulses during the first one.
        do_op(8'd100, 8'd7,  1, 1, 8'h0E, 8'h02, 1'b0, 1'b0);
        do_op(8'h9C,  8'd7,  0, 1, 8'hF2, 8'hFE, 1'b0, 1'b0);
        do_op(8'd100, 8'hF9, 0, 1, 8'hF2, 8'h02, 1'b0, 1'b0);
        do_op(8'h9C,  8'hF9, 0, 1, 8'h0E, 8'hFE, 1'b0, 1'b0);
        do_op(8'd5,   8'd0,  0, 1, 8'hFF, 8'h05, 1'b1, 1'b0);
        do_op(8'd6,   8'd3,  0, 1, 8'h02, 8'h00, 1'b0, 1'b0);
        do_op(8'h80,  8'hFF, 0, 1, 8'h80, 8'h00, 1'b0, 1'b1);
        do_op(8'h80,  8'd1,  0, 1, 8'h80, 8'h00, 1'b0, 1'b0);
        do_op(8'd127, 8'd127,0, 1, 8'h01, 8'h00, 1'b0, 1'b0);

        // Start held high through done: second op accepted right after done.
        @(posedge clk); #1;
        dividend = 8'd20; divisor = 8'd3; start = 1'b1;
        wait_done(n);
        chk("hold_lat1", 8'(n), 8'd11);
        chk("hold_q1", quotient, 8'h06);
        chk("hold_r1", remainder, 8'h02);
        dividend = 8'hCE; divisor = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        chk("hold_lat2", 8'(n), 8'd10);
        chk("hold_q2", quotient, 8'hF4);
        chk("hold_r2", remainder, 8'hFE);

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_done", {7'd0, done}, 8'd0);
        chk("mid_rst_quot", quotient, 8'h00);
        chk("mid_rst_rem", remainder, 8'h00);
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("mid_rst_no_done", 8'(dcnt), 8'd0);
        do_op(8'd9, 8'd2, 0, 1, 8'h04, 8'h01, 1'b0, 1'b0);

        // Randomized operations with occasional special operands and idle gaps.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: begin ra = 8'h80; rb = 8'hFF; end
                2: ra = 8'h80;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(ra, rb, ($urandom_range(0, 3) == 0), 0, 8'h00, 8'h00, 1'b0, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_divider8.md
Name: seq_divider8

Overview:
- Iterative signed integer divider: the inverse operation of the team's sequential Booth multiplier.
- Accepts an 8-bit two's-complement dividend and divisor and produces an 8-bit quotient and 8-bit remainder, truncating toward zero, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath.
- Uses a start/done handshake so a controller can sequence multiply and divide operations on the same clock.

Parameters:
- WIDTH, 8: operand, quotient and remainder width in bits.
- CNT_W, 4: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; captured when start is accepted.
- divisor  input  WIDTH  signed divisor; captured when start is accepted.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- dbz  output  1  divide-by-zero flag for the last result.
- ovf  output  1  overflow flag (-2^(WIDTH-1) / -1) for the last result.

Behaviour:
- Reset: when rst_n=0 at a clock edge, state=IDLE, and quotient, remainder, busy, done, dbz, ovf and the counter all go to 0. Reset mid-operation aborts the operation and no done is produced.
- FSM states: IDLE, LOAD, ITER, FIX.
- IDLE: start=1 latches the operands and moves to LOAD. While busy, start is ignored.
- LOAD (1 cycle):
  - Store the magnitudes |dividend| and |divisor| as unsigned WIDTH-bit values. |-128| = 8'h80 is treated as unsigned 128.
  - Record sign_q = dividend[MSB] ^ divisor[MSB] and sign_r = dividend[MSB].
  - Clear the partial remainder P (WIDTH+1 bits) and set count=0.
  - Set dbz = (divisor==0) and ovf = (dividend==8'h80 && divisor==8'hFF).
- ITER (exactly WIDTH cycles), restoring division:
  - Shift {P,Q} left by 1, bringing in the next dividend bit.
  - Compute T = P - {0,|divisor|}.
  - If T[MSB]==0: P=T and Q[0]=1. Otherwise P is unchanged and Q[0]=0.
  - count increments each cycle; leave ITER after count==WIDTH-1.
- FIX (1 cycle):
  - quotient = sign_q ? -Q : Q.
  - remainder = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - Assert done for this cycle only, then return to IDLE.
- Special results, applied in FIX:
  - dbz=1: quotient=all ones (-1), remainder=original dividend.
  - ovf=1: quotient=8'h80, remainder=0.
  - Timing for both cases is identical to normal operation.
- Latency: with start sampled at edge N, busy=1 from edge N+1 through edge N+WIDTH+1 and done=1 after edge N+WIDTH+2, i.e. WIDTH+2 cycles (10 for WIDTH=8). busy falls when done rises.
- Back-to-back: the earliest new start is accepted on the edge after the done cycle (IDLE). If start is high during the done cycle, it is accepted on the next edge.
- Outputs quotient, remainder, dbz and ovf hold their values until the next FIX.
- Arithmetic: negation is two's complement within WIDTH bits. The subtraction uses add-with-inverted-operand and carry-in=1. No internal width exceeds WIDTH+1.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, LOAD=2'd1, ITER=2'd2, FIX=2'd3), WIDTH and CNT_W defaults, and the dbz quotient constant (all ones).
- One natural sub-module: the team's existing adder8bit, instantiated as a subtractor with the inverted divisor magnitude and cin=1, computing T (extended to WIDTH+1 bits via the carry-out).
- Sign handling and the FSM live in the top module.

Test Plan:
- 100 / 7: start at cycle 0 -> done at cycle 10, quotient=8'h0E (14), remainder=8'h02, dbz=0, ovf=0; busy high cycles 1-9.
- -100 / 7 -> quotient=8'hF2 (-14), remainder=8'hFE (-2). Then 100 / -7 -> quotient=8'hF2, remainder=8'h02. Then -100 / -7 -> quotient=8'h0E, remainder=8'hFE.
- 5 / 0 -> done after 10 cycles, quotient=8'hFF, remainder=8'h05, dbz=1. Next 6 / 3 -> quotient=8'h02, remainder=0, dbz=0.
- -128 / -1 -> quotient=8'h80, remainder=0, ovf=1. Also -128 / 1 -> quotient=8'h80, ovf=0. Also 127 / 127 -> quotient=1, remainder=0.
- Start pulsed again at cycles 3 and 7 during the 100 / 7 operation -> ignored, result unchanged. Start held high through done -> second operation accepted the cycle after done, and its done arrives exactly 10 cycles later.
- rst_n=0 at cycle 5 of an operation -> next edge: busy=0, done=0, quotient=0, remainder=0, state IDLE. No done pulse follows, and a new 9 / 2 completes with quotient=4, remainder=1.
